// File: rtl/l2_arbiter_nch_ctrl_if.sv
// Bundle between the L2 arbiter controller, its requestors and the shared L2 port.
// master: the arbiter side; slave: the requestor/L2 side.
interface l2_arbiter_nch_ctrl_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32
);
  localparam int unsigned SelW = $clog2(NUM_REQ + 1);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic                      l2_resp;
  logic                      grant_valid;
  logic [SelW-1:0]           grant_sel;
  logic                      pf_read;
  logic [ADDR_W-1:0]         pf_addr;

  modport master (
    input  req,
    input  req_addr,
    input  l2_resp,
    output grant_valid,
    output grant_sel,
    output pf_read,
    output pf_addr
  );

  modport slave (
    output req,
    output req_addr,
    output l2_resp,
    input  grant_valid,
    input  grant_sel,
    input  pf_read,
    input  pf_addr
  );
endinterface

// File: rtl/l2_arbiter_nch_ctrl.sv
// Fixed-priority N-channel L2 port arbiter with anti-starvation override.
// Define L2_ARB_PREFETCH_EN to add the next-line prefetcher that fills idle L2 cycles.
module l2_arbiter_nch_ctrl #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LINE_BYTES   = 32,
  parameter int unsigned PF_SRC       = 1,
  parameter int unsigned PF_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  l2_arbiter_nch_ctrl_if.master bus
);
  localparam int unsigned SelW = $clog2(NUM_REQ + 1);
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StServe, StPf} state_e;

  state_e          state_q, state_d;
  logic [SelW-1:0] owner_q, owner_d;
  logic [CntW-1:0] cnt_q [NUM_REQ];
  logic [CntW-1:0] cnt_d [NUM_REQ];
  logic            grant;
  logic [SelW-1:0] win;
  logic            any_starved;
  logic [SelW-1:0] starved_idx;
  logic [SelW-1:0] req_idx;
  logic            pf_pending;
  logic            unused_addr;

  assign unused_addr = ^bus.req_addr;

  // Reverse scan so the lowest index is the one left standing.
  always_comb begin
    any_starved = 1'b0;
    starved_idx = '0;
    req_idx     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cnt_q[i] == Limit) begin
        any_starved = 1'b1;
        starved_idx = SelW'(i);
      end
      if (bus.req[i]) begin
        req_idx = SelW'(i);
      end
    end
    win = any_starved ? starved_idx : req_idx;
  end

  assign grant = (state_q == StIdle) && !bus.l2_resp && (|bus.req);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!bus.req[i]) begin
        cnt_d[i] = '0;
      end else if (grant && (win == SelW'(i))) begin
        cnt_d[i] = '0;
      end else if (!((state_q == StServe) && (owner_q == SelW'(i))) && (cnt_q[i] != Limit)) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = StServe;
          owner_d = win;
        end else if (!bus.l2_resp && pf_pending) begin
          state_d = StPf;
        end
      end
      StServe: if (bus.l2_resp) state_d = StIdle;
      StPf:    if (bus.l2_resp) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.grant_valid = (state_q == StServe);

`ifdef L2_ARB_PREFETCH_EN
  localparam int unsigned RemW = $clog2(PF_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(LINE_BYTES);
  localparam logic [ADDR_W-1:0] LineMask = ~(LineStep - ADDR_W'(1));

  logic [ADDR_W-1:0] pf_base_q, pf_base_d;
  logic [RemW-1:0]   pf_rem_q, pf_rem_d;

  assign pf_pending = (pf_rem_q != '0);

  // A fresh seed overrides whatever series was still outstanding.
  always_comb begin
    pf_base_d = pf_base_q;
    pf_rem_d  = pf_rem_q;
    if ((state_q == StServe) && bus.l2_resp && (owner_q == SelW'(PF_SRC))) begin
      pf_base_d = (bus.req_addr[PF_SRC*ADDR_W +: ADDR_W] & LineMask) + LineStep;
      pf_rem_d  = RemW'(PF_DEPTH);
    end else if ((state_q == StPf) && bus.l2_resp) begin
      pf_base_d = pf_base_q + LineStep;
      pf_rem_d  = pf_rem_q - RemW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_base_q <= '0;
      pf_rem_q  <= '0;
    end else begin
      pf_base_q <= pf_base_d;
      pf_rem_q  <= pf_rem_d;
    end
  end

  always_comb begin
    bus.grant_sel = '0;
    if (state_q == StServe) bus.grant_sel = owner_q;
    else if (state_q == StPf) bus.grant_sel = SelW'(NUM_REQ);
  end

  assign bus.pf_read = (state_q == StPf);
  assign bus.pf_addr = (state_q == StPf) ? pf_base_q : '0;
`else
  logic unused_cfg;

  assign unused_cfg    = ^{1'(PF_SRC), 1'(PF_DEPTH), 1'(LINE_BYTES)};
  assign pf_pending    = 1'b0;
  assign bus.grant_sel = (state_q == StServe) ? owner_q : '0;
  assign bus.pf_read   = 1'b0;
  assign bus.pf_addr   = '0;
`endif

endmodule

// File: tb/tb_l2_arbiter_nch_ctrl.sv
// Bench for l2_arbiter_nch_ctrl: directed scenarios plus random traffic against a
// transaction-level reference model. Honours L2_ARB_PREFETCH_EN like the design.
module tb_l2_arbiter_nch_ctrl;
  localparam int NReq  = 2;
  localparam int AW    = 32;
  localparam int Line  = 32;
  localparam int PfSrc = 1;
  localparam int PfDep = 2;
  localparam int Limit = 4;
`ifdef L2_ARB_PREFETCH_EN
  localparam bit PfOn = 1'b1;
`else
  localparam bit PfOn = 1'b0;
`endif
  localparam int MIdle = 0, MServe = 1, MPf = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  l2_arbiter_nch_ctrl_if #(.NUM_REQ(NReq), .ADDR_W(AW)) bus ();

  l2_arbiter_nch_ctrl #(
    .NUM_REQ(NReq), .ADDR_W(AW), .LINE_BYTES(Line), .PF_SRC(PfSrc),
    .PF_DEPTH(PfDep), .STARVE_LIMIT(Limit)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: who owns the port, how long each channel has waited, prefetch series.
  int          m_mode  = MIdle;
  int          m_owner = 0;
  int          m_wait [NReq];
  logic [31:0] m_base  = '0;
  int          m_left  = 0;

  task automatic model_tick();
    int win;
    bit take;
    if (rst) begin
      m_mode = MIdle; m_owner = 0; m_base = '0; m_left = 0;
      for (int i = 0; i < NReq; i++) m_wait[i] = 0;
      return;
    end
    win  = -1;
    take = 1'b0;
    if (m_mode == MIdle && !bus.l2_resp && bus.req != '0) begin
      for (int i = 0; i < NReq; i++) if (win < 0 && m_wait[i] == Limit) win = i;
      for (int i = 0; i < NReq; i++) if (win < 0 && bus.req[i]) win = i;
      take = 1'b1;
    end
    for (int i = 0; i < NReq; i++) begin
      if (!bus.req[i]) m_wait[i] = 0;
      else if (take && win == i) m_wait[i] = 0;
      else if (!(m_mode == MServe && m_owner == i))
        m_wait[i] = (m_wait[i] + 1 > Limit) ? Limit : m_wait[i] + 1;
    end
    case (m_mode)
      MIdle: begin
        if (take) begin
          m_mode  = MServe;
          m_owner = win;
        end else if (!bus.l2_resp && m_left > 0) begin
          m_mode = MPf;
        end
      end
      MServe: if (bus.l2_resp) begin
        if (PfOn && m_owner == PfSrc) begin
          m_base = (bus.req_addr[PfSrc*AW +: AW] & ~32'(Line - 1)) + 32'(Line);
          m_left = PfDep;
        end
        m_mode = MIdle;
      end
      default: if (bus.l2_resp) begin
        m_base = m_base + 32'(Line);
        m_left = m_left - 1;
        m_mode = MIdle;
      end
    endcase
  endtask

  initial for (int i = 0; i < NReq; i++) m_wait[i] = 0;

  always @(posedge clk or posedge rst) model_tick();

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    logic        e_gv, e_pf;
    logic [1:0]  e_sel;
    e_gv  = (m_mode == MServe);
    e_pf  = (m_mode == MPf);
    e_sel = (m_mode == MServe) ? 2'(m_owner) : (m_mode == MPf) ? 2'(NReq) : 2'd0;
    n_tests++;
    if (bus.grant_valid !== e_gv || bus.grant_sel !== e_sel || bus.pf_read !== e_pf ||
        (e_pf && bus.pf_addr !== m_base)) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t got gv=%0b sel=%0d pf=%0b addr=%0h want gv=%0b sel=%0d pf=%0b addr=%0h",
               $time, bus.grant_valid, bus.grant_sel, bus.pf_read, bus.pf_addr,
               e_gv, e_sel, e_pf, m_base);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic resp);
    bus.req     = r;
    bus.l2_resp = resp;
  endtask

  task automatic set_addr(input int ch, input logic [31:0] a);
    bus.req_addr[ch*AW +: AW] = a;
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
    return $urandom();
  endfunction

  initial begin
    int          drop_ch;
    logic [1:0]  exp_arb [3];
    exp_arb[0] = 2'd0; exp_arb[1] = 2'd0; exp_arb[2] = 2'd1;
    bus.req = '0; bus.req_addr = '0; bus.l2_resp = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset grant_valid", 32'(bus.grant_valid), 0);
    chk("reset grant_sel", 32'(bus.grant_sel), 0);
    chk("reset pf_read", 32'(bus.pf_read), 0);
    chk("reset pf_addr", bus.pf_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    // Fixed priority, mandatory idle gap, then the seed from channel 1 at 0x1004.
    set_addr(0, 32'h0000_2000);
    set_addr(1, 32'h0000_1004);
    drive(2'b11, 1'b0); @(negedge clk);
    chk("t1 first grant_valid", 32'(bus.grant_valid), 1);
    chk("t1 first grant_sel", 32'(bus.grant_sel), 0);
    drive(2'b11, 1'b0); @(negedge clk);
    drive(2'b11, 1'b1); @(negedge clk);
    chk("t1 idle gap grant_valid", 32'(bus.grant_valid), 0);
    drive(2'b10, 1'b0); @(negedge clk);
    chk("t1 second grant_valid", 32'(bus.grant_valid), 1);
    chk("t1 second grant_sel", 32'(bus.grant_sel), 1);
    drive(2'b10, 1'b0); @(negedge clk);
    drive(2'b10, 1'b1); @(negedge clk);
    chk("t2 idle after seed pf_read", 32'(bus.pf_read), 0);
    drive(2'b00, 1'b0); @(negedge clk);
    chk("t2 pf1 pf_read", 32'(bus.pf_read), 32'(PfOn));
    chk("t2 pf1 pf_addr", bus.pf_addr, PfOn ? 32'h0000_1020 : 32'h0);
    chk("t2 pf1 grant_sel", 32'(bus.grant_sel), PfOn ? 2 : 0);
    drive(2'b00, 1'b0); @(negedge clk);
    drive(2'b00, 1'b1); @(negedge clk);
    chk("t2 gap pf_read", 32'(bus.pf_read), 0);
    drive(2'b00, 1'b0); @(negedge clk);
    chk("t2 pf2 pf_addr", bus.pf_addr, PfOn ? 32'h0000_1040 : 32'h0);
    drive(2'b00, 1'b0); @(negedge clk);
    drive(2'b00, 1'b1); @(negedge clk);
    drive(2'b00, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("t2 series done pf_read", 32'(bus.pf_read), 0);
    end

    // Both channels held: starvation override hands arbitration 3 to channel 1.
    drive(2'b11, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3 arbitration grant_sel", 32'(bus.grant_sel), 32'(exp_arb[k]));
      drive(2'b11, 1'b0); @(negedge clk);
      drive(2'b11, 1'b1); @(negedge clk);
      if (k == 2) begin
        set_addr(1, 32'hFFFF_FFE4);
        drive(2'b10, 1'b0);
      end else begin
        drive(2'b11, 1'b0);
      end
    end

    // Seed at the top of the address space wraps to zero.
    @(negedge clk);
    chk("t4 grant_sel", 32'(bus.grant_sel), 1);
    drive(2'b10, 1'b0); @(negedge clk);
    drive(2'b10, 1'b1); @(negedge clk);
    drive(2'b00, 1'b0); @(negedge clk);
    chk("t4 pf1 pf_read", 32'(bus.pf_read), 32'(PfOn));
    chk("t4 pf1 pf_addr", bus.pf_addr, 32'h0000_0000);
    drive(2'b00, 1'b0); @(negedge clk);
    drive(2'b00, 1'b1); @(negedge clk);
    drive(2'b00, 1'b0); @(negedge clk);
    chk("t4 pf2 pf_addr", bus.pf_addr, PfOn ? 32'h0000_0020 : 32'h0);

    // Asynchronous reset in the middle of a prefetch.
    #2 rst = 1'b1;
    #1;
    chk("t5 async pf_read", 32'(bus.pf_read), 0);
    chk("t5 async grant_sel", 32'(bus.grant_sel), 0);
    chk("t5 async grant_valid", 32'(bus.grant_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t5 no pf after reset", 32'(bus.pf_read), 0);
    end

    // l2_resp in IDLE blocks that cycle's decision.
    drive(2'b01, 1'b1); @(negedge clk);
    chk("t6 blocked grant_valid", 32'(bus.grant_valid), 0);
    drive(2'b01, 1'b0); @(negedge clk);
    chk("t6 late grant_valid", 32'(bus.grant_valid), 1);
    chk("t6 late grant_sel", 32'(bus.grant_sel), 0);
    drive(2'b01, 1'b0); @(negedge clk);
    drive(2'b01, 1'b1); @(negedge clk);
    drive(2'b00, 1'b0);

    // Random traffic; requests stay up (same address) until their transaction completes.
    drop_ch = -1;
    repeat (4000) begin
      @(negedge clk);
      if (drop_ch >= 0) begin
        if ($urandom_range(0, 1) == 0) bus.req[drop_ch] = 1'b0;
        else set_addr(drop_ch, rnd_addr());
        drop_ch = -1;
      end
      for (int i = 0; i < NReq; i++) begin
        if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
          set_addr(i, rnd_addr());
          bus.req[i] = 1'b1;
        end
      end
      if (m_mode != MIdle) bus.l2_resp = ($urandom_range(0, 2) == 0);
      else bus.l2_resp = ($urandom_range(0, 7) == 0);
      if (bus.l2_resp && m_mode == MServe) drop_ch = m_owner;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
